// File: rtl/kmc_npr_ctrl.sv
// rtl/kmc_npr_ctrl.sv - KMC11 NPR (DMA) bus-cycle sequencer with NXM timeout
module kmc_npr_ctrl #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kmcNPRSTART,
    input  logic        kmcNPRO,
    input  logic        kmcBYTE,
    input  logic [1:0]  kmcNPRXA,
    input  logic [15:0] kmcNPRIA,
    input  logic [15:0] kmcNPROA,
    input  logic [15:0] kmcNPROD,
    input  logic        devACKI,
    output logic        devREQO,
    output logic [35:0] devADDRO,
    output logic [35:0] devDATAO,
    output logic        devLOBYTE,
    output logic        devHIBYTE,
    output logic        kmcNPRBUSY,
    output logic        kmcNPRDONE,
    output logic        kmcNXM
);

    localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_NXM  = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_write;
    logic        r_byte;
    logic [17:0] r_addr;
    logic [15:0] r_data;
    logic        r_req;
    logic        r_busy;
    logic        r_done;
    logic        r_nxm;

    logic [7:0]  w_bsel;
    logic [15:0] w_wdata;

    // Sequencer: latch the request in IDLE, hold the bus request until ack or timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 18'd0;
            r_data  <= 16'd0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nxm   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (kmcNPRSTART) begin
                        r_write <= kmcNPRO;
                        r_byte  <= kmcBYTE;
                        r_addr  <= {kmcNPRXA, kmcNPRO ? kmcNPROA : kmcNPRIA};
                        r_data  <= kmcNPROD;
                        r_nxm   <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ack takes priority over an expiring timeout on the same cycle
                    if (devACKI) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == L_TIMEOUT) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_nxm   <= 1'b1;
                        r_state <= S_NXM;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE, S_NXM: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte writes replicate the selected byte into both halves of the word
    always_comb begin
        w_bsel  = r_addr[0] ? r_data[15:8] : r_data[7:0];
        w_wdata = r_byte ? {w_bsel, w_bsel} : r_data;
    end

    assign devREQO    = r_req;
    assign devADDRO   = r_req ? {r_write, ~r_write, r_byte, 15'd0, r_addr} : 36'd0;
    assign devDATAO   = (r_req && r_write) ? {2'b00, w_wdata, 2'b00, w_wdata} : 36'd0;
    assign devLOBYTE  = r_req & (~r_byte | ~r_addr[0]);
    assign devHIBYTE  = r_req & (~r_byte | r_addr[0]);
    assign kmcNPRBUSY = r_busy;
    assign kmcNPRDONE = r_done;
    assign kmcNXM     = r_nxm;

endmodule

// File: tb/tb_kmc_npr_ctrl.sv
// tb/tb_kmc_npr_ctrl.sv - scoreboard bench for the NPR bus-cycle sequencer
module tb_kmc_npr_ctrl;

    logic        clk;
    logic        rst;
    logic        kmcNPRSTART;
    logic        kmcNPRO;
    logic        kmcBYTE;
    logic [1:0]  kmcNPRXA;
    logic [15:0] kmcNPRIA;
    logic [15:0] kmcNPROA;
    logic [15:0] kmcNPROD;
    logic        devACKI;
    logic        devREQO;
    logic [35:0] devADDRO;
    logic [35:0] devDATAO;
    logic        devLOBYTE;
    logic        devHIBYTE;
    logic        kmcNPRBUSY;
    logic        kmcNPRDONE;
    logic        kmcNXM;

    int total;
    int bad;

    typedef struct {
        logic [35:0] addr;
        logic [35:0] data;
        logic        lo;
        logic        hi;
    } exp_t;

    exp_t exp_q[$];

    kmc_npr_ctrl #(.TIMEOUT(63)) dut (
        .clk         (clk),
        .rst         (rst),
        .kmcNPRSTART (kmcNPRSTART),
        .kmcNPRO     (kmcNPRO),
        .kmcBYTE     (kmcBYTE),
        .kmcNPRXA    (kmcNPRXA),
        .kmcNPRIA    (kmcNPRIA),
        .kmcNPROA    (kmcNPROA),
        .kmcNPROD    (kmcNPROD),
        .devACKI     (devACKI),
        .devREQO     (devREQO),
        .devADDRO    (devADDRO),
        .devDATAO    (devDATAO),
        .devLOBYTE   (devLOBYTE),
        .devHIBYTE   (devHIBYTE),
        .kmcNPRBUSY  (kmcNPRBUSY),
        .kmcNPRDONE  (kmcNPRDONE),
        .kmcNXM      (kmcNXM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic wr, input logic by, input logic [1:0] xa,
                                   input logic [15:0] ia, input logic [15:0] oa,
                                   input logic [15:0] od);
        exp_t        e;
        logic [17:0] a;
        logic [7:0]  b;
        logic [15:0] d;
        a = {xa, wr ? oa : ia};
        e.addr = {wr, ~wr, by, 15'd0, a};
        if (!by) begin
            e.lo = 1'b1;
            e.hi = 1'b1;
        end else begin
            e.lo = ~a[0];
            e.hi = a[0];
        end
        b = a[0] ? od[15:8] : od[7:0];
        d = by ? {b, b} : od;
        e.data = wr ? {2'b00, d, 2'b00, d} : 36'd0;
        return e;
    endfunction

    // Called at #1 after a posedge; leaves the DUT in its first REQ cycle
    task automatic do_start(input logic wr, input logic by, input logic [1:0] xa,
                            input logic [15:0] ia, input logic [15:0] oa,
                            input logic [15:0] od);
        @(posedge clk); #1;
        kmcNPRSTART = 1'b1;
        kmcNPRO = wr;
        kmcBYTE = by;
        kmcNPRXA = xa;
        kmcNPRIA = ia;
        kmcNPROA = oa;
        kmcNPROD = od;
        exp_q.push_back(model(wr, by, xa, ia, oa, od));
        @(posedge clk); #1;
        kmcNPRSTART = 1'b0;
        kmcNPRO = $urandom_range(0, 1);
        kmcBYTE = $urandom_range(0, 1);
        kmcNPRIA = 16'($urandom);
        kmcNPROA = 16'($urandom);
        kmcNPROD = 16'($urandom);
    endtask

    task automatic check_bus(input string tag, input exp_t e);
        total++;
        if (devREQO !== 1'b1) begin
            bad++;
            $display("FAIL %s req: got %b want 1", tag, devREQO);
        end
        total++;
        if (devADDRO !== e.addr) begin
            bad++;
            $display("FAIL %s addr: got %h want %h", tag, devADDRO, e.addr);
        end
        total++;
        if (devDATAO !== e.data) begin
            bad++;
            $display("FAIL %s data: got %h want %h", tag, devDATAO, e.data);
        end
        total++;
        if ({devLOBYTE, devHIBYTE} !== {e.lo, e.hi}) begin
            bad++;
            $display("FAIL %s lanes lo/hi: got %b%b want %b%b", tag, devLOBYTE, devHIBYTE, e.lo, e.hi);
        end
    endtask

    // Waits w REQ cycles, acks for one cycle and checks the DONE pulse
    task automatic finish_ack(input string tag, input int w);
        repeat (w) begin
            @(posedge clk); #1;
        end
        total++;
        if (devREQO !== 1'b1) begin
            bad++;
            $display("FAIL %s req before ack: got %b want 1", tag, devREQO);
        end
        devACKI = 1'b1;
        @(posedge clk); #1;
        devACKI = 1'b0;
        total++;
        if ({kmcNPRDONE, devREQO, kmcNPRBUSY, kmcNXM} !== 4'b1010) begin
            bad++;
            $display("FAIL %s done/req/busy/nxm: got %b want 1010", tag,
                     {kmcNPRDONE, devREQO, kmcNPRBUSY, kmcNXM});
        end
        @(posedge clk); #1;
        total++;
        if ({kmcNPRDONE, kmcNPRBUSY, devADDRO, devDATAO} !== 74'd0) begin
            bad++;
            $display("FAIL %s idle after done: done=%b busy=%b addr=%h data=%h want 0",
                     tag, kmcNPRDONE, kmcNPRBUSY, devADDRO, devDATAO);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({devREQO, devLOBYTE, devHIBYTE, kmcNPRBUSY, kmcNPRDONE, kmcNXM} !== 6'd0) begin
            bad++;
            $display("FAIL reset strobes: got %b want 000000",
                     {devREQO, devLOBYTE, devHIBYTE, kmcNPRBUSY, kmcNPRDONE, kmcNXM});
        end
        total++;
        if ({devADDRO, devDATAO} !== 72'd0) begin
            bad++;
            $display("FAIL reset buses: addr=%h data=%h want 0", devADDRO, devDATAO);
        end
    endtask

    task automatic test_word_read();
        exp_t e;
        do_start(1'b0, 1'b0, 2'b01, 16'h1234, 16'h0000, 16'h0000);
        e = exp_q.pop_front();
        check_bus("word_read", e);
        total++;
        if (devADDRO !== 36'h4_0001_1234) begin
            bad++;
            $display("FAIL word_read literal addr: got %h want 400011234", devADDRO);
        end
        finish_ack("word_read", 3);
    endtask

    task automatic test_byte_write_odd();
        exp_t        e;
        logic [35:0] want;
        want = {2'b00, 16'hABAB, 2'b00, 16'hABAB};
        do_start(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0101, 16'hABCD);
        e = exp_q.pop_front();
        check_bus("byte_write_odd", e);
        total++;
        if ({devADDRO[35], devADDRO[33], devLOBYTE, devHIBYTE, devDATAO} !== {4'b1101, want}) begin
            bad++;
            $display("FAIL byte_write_odd literal: got %b%b%b%b %h want 1101 %h",
                     devADDRO[35], devADDRO[33], devLOBYTE, devHIBYTE, devDATAO, want);
        end
        finish_ack("byte_write_odd", 1);
    endtask

    task automatic test_patterns();
        exp_t        e;
        logic [15:0] ia;
        logic [15:0] oa;
        logic [15:0] od;
        for (int i = 0; i < 8; i++) begin
            ia = 16'($urandom);
            oa = 16'($urandom);
            od = 16'($urandom);
            do_start(i[0], i[1], 2'(i + 1), ia, oa, od);
            e = exp_q.pop_front();
            check_bus($sformatf("pattern%0d", i), e);
            finish_ack($sformatf("pattern%0d", i), i);
        end
    endtask

    task automatic test_timeout();
        int   n;
        exp_t e;
        do_start(1'b0, 1'b0, 2'b11, 16'hDEAD, 16'h0000, 16'h0000);
        e = exp_q.pop_front();
        check_bus("timeout", e);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (devREQO !== 1'b1) break;
            n++;
            @(posedge clk); #1;
        end
        total++;
        if (n != 64) begin
            bad++;
            $display("FAIL timeout req cycles: got %0d want 64", n);
        end
        total++;
        if ({kmcNPRDONE, kmcNXM, devREQO, devLOBYTE, devHIBYTE} !== 5'b11000) begin
            bad++;
            $display("FAIL timeout nxm entry done/nxm/req/lo/hi: got %b want 11000",
                     {kmcNPRDONE, kmcNXM, devREQO, devLOBYTE, devHIBYTE});
        end
        @(posedge clk); #1;
        total++;
        if ({kmcNPRDONE, kmcNXM, kmcNPRBUSY} !== 3'b010) begin
            bad++;
            $display("FAIL timeout after done/nxm/busy: got %b want 010",
                     {kmcNPRDONE, kmcNXM, kmcNPRBUSY});
        end
        do_start(1'b1, 1'b0, 2'b00, 16'h0000, 16'h2000, 16'h55AA);
        e = exp_q.pop_front();
        total++;
        if (kmcNXM !== 1'b0) begin
            bad++;
            $display("FAIL timeout nxm cleared by start: got %b want 0", kmcNXM);
        end
        check_bus("after_nxm", e);
        finish_ack("after_nxm", 0);
    endtask

    task automatic test_ack_final();
        exp_t e;
        do_start(1'b1, 1'b1, 2'b10, 16'h0000, 16'h0F0E, 16'h1357);
        e = exp_q.pop_front();
        check_bus("ack_final", e);
        finish_ack("ack_final", 63);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_start(1'b0, 1'b0, 2'b00, 16'h0F0E, 16'h0000, 16'h0000);
        e = exp_q.pop_front();
        kmcNPRSTART = 1'b1;
        kmcNPRO = 1'b1;
        kmcBYTE = 1'b1;
        kmcNPROA = 16'h5555;
        @(posedge clk); #1;
        kmcNPRSTART = 1'b0;
        check_bus("busy_ignore", e);
        finish_ack("busy_ignore", 2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (devREQO !== 1'b0) begin
                bad++;
                $display("FAIL busy_ignore stray req cycle %0d: got %b want 0", i, devREQO);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ack_idle();
        devACKI = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        devACKI = 1'b0;
        total++;
        if ({devREQO, kmcNPRDONE, kmcNPRBUSY} !== 3'b000) begin
            bad++;
            $display("FAIL ack_idle req/done/busy: got %b want 000",
                     {devREQO, kmcNPRDONE, kmcNPRBUSY});
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_start(1'b1, 1'b0, 2'b01, 16'h0000, 16'h4321, 16'hFEDC);
        e = exp_q.pop_front();
        @(posedge clk); #1;
        check_bus("async_reset", e);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({devREQO, devLOBYTE, devHIBYTE, kmcNPRBUSY, kmcNPRDONE, kmcNXM, devADDRO, devDATAO} !== 78'd0) begin
            bad++;
            $display("FAIL async_reset outputs: req=%b busy=%b addr=%h data=%h want 0",
                     devREQO, kmcNPRBUSY, devADDRO, devDATAO);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({kmcNPRDONE, devREQO} !== 2'b00) begin
                bad++;
                $display("FAIL async_reset stray done/req cycle %0d: got %b want 00",
                         i, {kmcNPRDONE, devREQO});
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        kmcNPRSTART = 1'b0;
        kmcNPRO = 1'b0;
        kmcBYTE = 1'b0;
        kmcNPRXA = 2'b00;
        kmcNPRIA = 16'd0;
        kmcNPROA = 16'd0;
        kmcNPROD = 16'd0;
        devACKI = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_word_read();
        test_byte_write_odd();
        test_patterns();
        test_timeout();
        test_ack_final();
        test_back_to_back();
        test_ack_idle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
